fib_arb: RTL
============

FIB_ARB -- requirements
Module: fib_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one fib engine.
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT cycles before an error response.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  N_REQ  per-requester level request.
REQ-006 req_i  input  5*N_REQ  per-requester fib index; slice k is bits [5k+4:5k].
REQ-007 gnt  output  N_REQ  one-hot owner of the engine, zero when idle.
REQ-008 rsp_valid  output  N_REQ  one-hot, single-cycle response strobe.
REQ-009 rsp_result  output  20  result returned with rsp_valid.
REQ-010 rsp_err  output  1  asserted with rsp_valid when the response is a timeout.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 eng_start  output  1  single-cycle start pulse to the engine.
REQ-013 eng_i  output  5  registered index to the engine; held from ISSUE through WAIT.
REQ-014 eng_done  input  1  engine completion flag.
REQ-015 eng_result  input  20  engine result; valid when eng_done is high.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-017 IDLE: if any unmasked req bit is high, the block SHALL select the winner k by round-robin, capture req_i slice k into eng_i, set gnt to 1<<k, and go to ISSUE.
REQ-018 Round-robin search SHALL start at index last_gnt+1 mod N_REQ; after reset, last_gnt SHALL equal N_REQ-1, giving index 0 first priority.
REQ-019 ISSUE (exactly one cycle): eng_start SHALL be 1; next state SHALL be WAIT, and the timeout counter SHALL clear to 0.
REQ-020 WAIT: eng_done SHALL be ignored in the first WAIT cycle, because a stale done from the previous operation is allowed.
- From the second WAIT cycle onward, eng_done=1 SHALL capture eng_result, clear rsp_err, and go to RESP.
REQ-021 WAIT: the counter SHALL increment every cycle; at count TIMEOUT-1 without a qualifying done, the block SHALL set rsp_result=0 and rsp_err=1, and go to RESP.
- If done and timeout occur in the same cycle, done SHALL win.
REQ-022 RESP (exactly one cycle): rsp_valid SHALL equal gnt, and rsp_result and rsp_err SHALL be valid.
- The next cycle SHALL return to IDLE with gnt=0, and last_gnt SHALL be updated to k.
REQ-023 In the first IDLE cycle after RESP, the just-served requester's req SHALL be masked; the mask SHALL clear after that one cycle.
REQ-024 rsp_result and rsp_err SHALL hold their last values outside RESP; rsp_valid SHALL be 0 outside RESP.
REQ-025 req and req_i changes after capture SHALL have no effect on the operation in flight.
- Deassertion of req by the owner mid-operation SHALL NOT abort; the response is still issued.
REQ-026 eng_done SHALL be ignored in IDLE, ISSUE and RESP; a late done after a timeout SHALL be discarded.
REQ-027 Best-case latency SHALL be: req sampled at cycle 0, eng_start at cycle 1, eng_done at cycle 3 at the earliest, rsp_valid at cycle 4.
REQ-028 rsp_result SHALL be the 20-bit engine value passed unmodified; no width conversion is permitted.

Reset
REQ-029 With rst=1 at a clock edge, the state SHALL become IDLE, and gnt, rsp_valid, rsp_result, rsp_err, busy, eng_start and eng_i SHALL be 0.
- The counter and mask SHALL clear, and last_gnt SHALL be N_REQ-1.
REQ-030 Reset in any state, including mid-WAIT, SHALL abandon the operation with no rsp_valid; an engine done arriving afterwards SHALL be ignored.

Verification
REQ-031 Single request, with an engine model that returns 55 for i=10 and asserts done 5 cycles after start:
- req=0001, req_i[4:0]=10 -> eng_start at cycle 1 with eng_i=10; rsp_valid=0001, rsp_result=55, rsp_err=0 at cycle 7.
REQ-032 Contention: req=1111 held with indices 1,2,3,4 -> grants served in order 0,1,2,3.
- Each requester SHALL receive exactly one rsp_valid with its own result before any requester is served twice.
REQ-033 Stale done: eng_done held at 1 from the prior operation -> no response in the first WAIT cycle; the response follows the fresh done.
REQ-034 Timeout: the engine never asserts done, with TIMEOUT=64 -> rsp_valid with rsp_err=1 and rsp_result=0 exactly TIMEOUT cycles after the first WAIT cycle.
- A late done injected afterwards SHALL produce no response.
REQ-035 Reset mid-WAIT: rst pulsed for 1 cycle during WAIT -> all outputs 0 the next cycle and no rsp_valid.
- The next req=0100 SHALL be granted normally.
REQ-036 Wide result: the model returns 20'hFFFFF for i=31 -> rsp_result=20'hFFFFF with no truncation.

Source files
------------

// File: rtl/fib_arb.sv
`default_nettype none
// ============================================================================
//  Module   : fib_arb
//  Purpose  : Round-robin arbiter that shares one Fibonacci engine between
//             N_REQ requesters. It issues a start pulse, waits for the engine
//             (with a timeout), and returns a one-cycle response strobe to
//             the requester that owns the engine.
//  Revision : 1.0  initial release
// ============================================================================
module fib_arb #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [5*N_REQ-1:0]   req_i,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [19:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 eng_start,
  output logic [4:0]           eng_i,
  input  logic                 eng_done,
  input  logic [19:0]          eng_result
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Counter is one bit wider than needed for TIMEOUT-1 so the increment
  // can never wrap while still in WAIT.
  localparam int CNTW = $clog2(TIMEOUT) + 1;
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(N_REQ - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,      state_d;
  logic [N_REQ-1:0] gnt_q,        gnt_d;
  logic [IDXW-1:0]  owner_q,      owner_d;
  logic [IDXW-1:0]  last_gnt_q,   last_gnt_d;
  logic [N_REQ-1:0] mask_q,       mask_d;
  logic [CNTW-1:0]  cnt_q,        cnt_d;
  logic [4:0]       eng_i_q,      eng_i_d;
  logic             eng_start_q,  eng_start_d;
  logic [N_REQ-1:0] rsp_valid_q,  rsp_valid_d;
  logic [19:0]      rsp_result_q, rsp_result_d;
  logic             rsp_err_q,    rsp_err_d;
  logic             busy_q,       busy_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [4:0]       slice_arr [N_REQ];
  logic [N_REQ-1:0] req_eff;
  logic             win_found;
  logic [IDXW-1:0]  win_idx;
  logic [IDXW-1:0]  cand_idx;
  int               cand;
  logic             done_ok;
  logic             timeout_hit;

  // Unpack the flat index bus into one 5-bit index per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign slice_arr[g] = req_i[5*g +: 5];
  end

  // The requester served last is excluded for exactly one IDLE cycle.
  assign req_eff = req & ~mask_q;

  // A done in the first WAIT cycle (count 0) may be left over from the
  // previous operation, so it only counts from the second cycle on.
  assign done_ok     = (state_q == S_WAIT) && eng_done && (cnt_q != '0);
  assign timeout_hit = (state_q == S_WAIT) && (cnt_q == CNTW'(TIMEOUT - 1));

  // Round-robin search starting one past the last served requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand     = (int'(last_gnt_q) + i) % N_REQ;
      cand_idx = IDXW'(cand);
      if (!win_found && req_eff[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // State register plus all registered outputs and datapath state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      owner_q      <= '0;
      last_gnt_q   <= LAST_RST;
      mask_q       <= '0;
      cnt_q        <= '0;
      eng_i_q      <= '0;
      eng_start_q  <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      owner_q      <= owner_d;
      last_gnt_q   <= last_gnt_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      eng_i_q      <= eng_i_d;
      eng_start_q  <= eng_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (done_ok || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    last_gnt_d   = last_gnt_q;
    mask_d       = '0;
    cnt_d        = cnt_q;
    eng_i_d      = eng_i_q;
    eng_start_d  = 1'b0;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d       = N_REQ'(1) << win_idx;
          owner_d     = win_idx;
          eng_i_d     = slice_arr[win_idx];
          eng_start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNTW'(1);
        // A qualifying done takes priority over a simultaneous timeout.
        if (done_ok) begin
          rsp_result_d = eng_result;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = gnt_q;
        end else if (timeout_hit) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = gnt_q;
        end
      end
      S_RESP: begin
        gnt_d      = '0;
        last_gnt_d = owner_q;
        mask_d     = gnt_q;
      end
      default: ;
    endcase
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign eng_start  = eng_start_q;
  assign eng_i      = eng_i_q;

endmodule
`default_nettype wire
